// File: rtl/svm_sched_pkg.sv
// svm_sched_pkg: shared scheduler constants and transaction type
//   SVM_MAX_DEPENDENCIES : default read/write dependency vector width
//   svm_txn_t            : one ingress transaction {owner_programID, read_deps, write_deps}
package svm_sched_pkg;
    localparam int SVM_MAX_DEPENDENCIES = 256;
    typedef struct packed {
        logic [63:0]                     owner_programID;
        logic [SVM_MAX_DEPENDENCIES-1:0] read_deps;
        logic [SVM_MAX_DEPENDENCIES-1:0] write_deps;
    } svm_txn_t;
endpackage

// File: rtl/svm_ingress_arbiter_if.sv
// svm_ingress_arbiter_if: granted-transaction stream from the arbiter to the scheduler ingress
//   tvalid / tready                      : AXI-Stream handshake
//   tdata_owner_programID                : 64-bit owner program ID
//   tdata_read/write_dependencies        : MAX_DEPENDENCIES-bit dependency vectors
//   tsrc                                 : index of the source that supplied the beat
//   modport master : arbiter side; modport slave : scheduler side
interface svm_ingress_arbiter_if
    import svm_sched_pkg::*;
#(
    parameter int NUM_SRC          = 4,
    parameter int MAX_DEPENDENCIES = SVM_MAX_DEPENDENCIES
) ();
    localparam int SRC_IDX_W = $clog2(NUM_SRC);
    logic                        tvalid;
    logic                        tready;
    logic [63:0]                 tdata_owner_programID;
    logic [MAX_DEPENDENCIES-1:0] tdata_read_dependencies;
    logic [MAX_DEPENDENCIES-1:0] tdata_write_dependencies;
    logic [SRC_IDX_W-1:0]        tsrc;
    modport master (
        output tvalid, tdata_owner_programID, tdata_read_dependencies, tdata_write_dependencies, tsrc,
        input  tready
    );
    modport slave (
        input  tvalid, tdata_owner_programID, tdata_read_dependencies, tdata_write_dependencies, tsrc,
        output tready
    );
endinterface

// File: rtl/svm_rr_picker.sv
// svm_rr_picker: combinational round-robin find-first
//   req     : request vector
//   ptr     : highest-priority index this cycle
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : index of the granted request
//   any     : at least one request present
module svm_rr_picker #(
    parameter  int NUM_SRC   = 4,
    localparam int SRC_IDX_W = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]   req,
    input  logic [SRC_IDX_W-1:0] ptr,
    output logic [NUM_SRC-1:0]   gnt,
    output logic [SRC_IDX_W-1:0] gnt_idx,
    output logic                 any
);
    function automatic logic [SRC_IDX_W-1:0] wrap(input int v);
        return SRC_IDX_W'(v >= NUM_SRC ? v - NUM_SRC : v);
    endfunction
    // Scan farthest-from-ptr first so the candidate closest to ptr wins.
    always_comb begin
        gnt_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (req[wrap(int'(ptr) + k)]) gnt_idx = wrap(int'(ptr) + k);
    end
    assign any = |req;
    assign gnt = any ? NUM_SRC'(1) << gnt_idx : '0;
endmodule

// File: rtl/svm_ingress_arbiter.sv
// svm_ingress_arbiter: work-conserving round-robin share of the scheduler ingress stream
//   clk, rst_n           : clock, asynchronous active-low reset
//   src_enable           : per-source grant mask
//   s_axis_*             : NUM_SRC packed requester streams (source i at slice i)
//   m_axis               : registered granted stream toward the scheduler
//   busy                 : output beat pending or any enabled source valid
//   grant_count, stall_cycles : statistics, present only with SVM_ARB_STATS_EN defined
module svm_ingress_arbiter
    import svm_sched_pkg::*;
#(
    parameter int NUM_SRC          = 4,
    parameter int MAX_DEPENDENCIES = SVM_MAX_DEPENDENCIES
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_SRC-1:0]                  src_enable,
    input  logic [NUM_SRC-1:0]                  s_axis_tvalid,
    output logic [NUM_SRC-1:0]                  s_axis_tready,
    input  logic [NUM_SRC*64-1:0]               s_axis_tdata_owner_programID,
    input  logic [NUM_SRC*MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
    input  logic [NUM_SRC*MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
    svm_ingress_arbiter_if.master               m_axis,
    output logic                                busy
`ifdef SVM_ARB_STATS_EN
    ,
    output logic [NUM_SRC*32-1:0]               grant_count,
    output logic [31:0]                         stall_cycles
`endif
);
    localparam int SRC_IDX_W = $clog2(NUM_SRC);
    logic                        free;
    logic                        any;
    logic [NUM_SRC-1:0]          gnt;
    logic [SRC_IDX_W-1:0]        gnt_idx;
    logic [SRC_IDX_W-1:0]        rr_ptr;
    logic [63:0]                 nxt_own;
    logic [MAX_DEPENDENCIES-1:0] nxt_rd;
    logic [MAX_DEPENDENCIES-1:0] nxt_wr;
    assign free = !m_axis.tvalid || m_axis.tready;
    // Masking the requests with free keeps every ready low while a beat is stalled.
    svm_rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
        .req     (free ? s_axis_tvalid & src_enable : '0),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );
    assign s_axis_tready = rst_n ? gnt : '0;
    assign busy = m_axis.tvalid || |(s_axis_tvalid & src_enable);
    always_comb begin
        nxt_own = '0;
        nxt_rd  = '0;
        nxt_wr  = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (gnt[i]) begin
                nxt_own = s_axis_tdata_owner_programID[i*64 +: 64];
                nxt_rd  = s_axis_tdata_read_dependencies[i*MAX_DEPENDENCIES +: MAX_DEPENDENCIES];
                nxt_wr  = s_axis_tdata_write_dependencies[i*MAX_DEPENDENCIES +: MAX_DEPENDENCIES];
            end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis.tvalid                   <= 1'b0;
            m_axis.tdata_owner_programID    <= '0;
            m_axis.tdata_read_dependencies  <= '0;
            m_axis.tdata_write_dependencies <= '0;
            m_axis.tsrc                     <= '0;
            rr_ptr                          <= '0;
        end else if (any) begin
            m_axis.tvalid                   <= 1'b1;
            m_axis.tdata_owner_programID    <= nxt_own;
            m_axis.tdata_read_dependencies  <= nxt_rd;
            m_axis.tdata_write_dependencies <= nxt_wr;
            m_axis.tsrc                     <= gnt_idx;
            rr_ptr                          <= gnt_idx == SRC_IDX_W'(NUM_SRC - 1) ? '0 : gnt_idx + 1'b1;
        end else if (m_axis.tready) begin
            m_axis.tvalid                   <= 1'b0;
        end
    end
`ifdef SVM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count  <= '0;
            stall_cycles <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++)
                if (gnt[i]) grant_count[i*32 +: 32] <= grant_count[i*32 +: 32] + 32'd1;
            if (m_axis.tvalid && !m_axis.tready) stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif
endmodule
